// File: rtl/ram_port_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : ram_arb_pkg
//  Purpose  : Shared helpers and constants for the RAM port arbiter.
//  Revision : 1.0  initial release
// ============================================================================
package ram_arb_pkg;

    // Largest supported requester count.
    localparam int MAX_NREQ = 16;

    // Index width that stays legal for a count of 1 as well.
    function automatic int idx_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // Requester index wide enough to hold ptr + offset (up to 2*MAX_NREQ-2)
    // before the modulo wrap is applied.
    typedef logic [4:0] req_idx_t;

    // Command driven onto the RAM port when nobody is granted.
    localparam logic        IDLE_WR   = 1'b0;
    localparam int unsigned IDLE_ADDR = 0;
    localparam int unsigned IDLE_DIN  = 0;

endpackage
`default_nettype wire

// File: rtl/ram_port_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : ram_port_arbiter_if
//  Purpose  : Requester-side command / response bundle of the RAM arbiter.
//  Revision : 1.0  initial release
// ============================================================================
interface ram_port_arbiter_if #(
    parameter int NREQ = 4,
    parameter int DW   = 8,
    parameter int AW   = 8
);
    logic [NREQ-1:0]          req_valid;
    logic [NREQ-1:0]          req_ready;
    logic [NREQ-1:0]          req_wr;
    logic [NREQ-1:0][AW-1:0]  req_addr;
    logic [NREQ-1:0][DW-1:0]  req_din;
    logic [NREQ-1:0]          rsp_valid;
    logic [DW-1:0]            rsp_data;

    // Client side: issues commands, sinks responses.
    modport master (
        output req_valid, req_wr, req_addr, req_din,
        input  req_ready, rsp_valid, rsp_data
    );

    // Arbiter side.
    modport slave (
        input  req_valid, req_wr, req_addr, req_din,
        output req_ready, rsp_valid, rsp_data
    );
endinterface
`default_nettype wire

// File: rtl/ram_port_arbiter_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : rr_arbiter
//  Purpose  : Round-robin one-hot grant with a rotating priority pointer.
//             Grant is purely combinational from i_req and the pointer.
//  Revision : 1.0  initial release
// ============================================================================
module rr_arbiter
    import ram_arb_pkg::*;
#(
    parameter int NREQ = 4,
    localparam int IW  = idx_width(NREQ)
) (
    input  wire logic            clk,
    input  wire logic            rst_n,
    input  wire logic [NREQ-1:0] i_req,
    input  wire logic            i_advance,
    output logic      [NREQ-1:0] o_gnt,
    output logic      [IW-1:0]   o_gnt_idx
);

    logic [IW-1:0]   r_ptr;
    logic [NREQ-1:0] w_gnt;
    logic [IW-1:0]   w_idx;
    logic            w_found;
    req_idx_t        w_pos;

    // Search ptr, ptr+1, ... (mod NREQ) and grant the first valid requester.
    always_comb begin
        w_gnt   = '0;
        w_idx   = '0;
        w_found = 1'b0;
        w_pos   = '0;
        for (int k = 0; k < NREQ; k++) begin
            w_pos = req_idx_t'(r_ptr) + req_idx_t'(k);
            if (w_pos >= req_idx_t'(NREQ)) begin
                w_pos = w_pos - req_idx_t'(NREQ);
            end
            for (int i = 0; i < NREQ; i++) begin
                if (!w_found && (w_pos == req_idx_t'(i)) && i_req[i]) begin
                    w_gnt[i] = 1'b1;
                    w_idx    = IW'(i);
                    w_found  = 1'b1;
                end
            end
        end
    end

    assign o_gnt     = w_gnt;
    assign o_gnt_idx = w_idx;

    // Pointer moves to the requester after the one just granted; holds otherwise.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ptr <= '0;
        end else if (i_advance) begin
            if (w_idx == IW'(NREQ - 1)) begin
                r_ptr <= '0;
            end else begin
                r_ptr <= w_idx + IW'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/ram_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : ram_port_arbiter
//  Purpose  : Shares one synchronous RAM port (1-cycle read, read-first)
//             among NREQ requesters. Round-robin grant, command mux and
//             1-cycle response routing.
//             Timing note: req_valid -> req_ready -> ram_* is combinational.
//  Revision : 1.0  initial release
// ============================================================================
module ram_port_arbiter
    import ram_arb_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int DW    = 8,
    parameter int WORDS = 256,
    localparam int AW   = idx_width(WORDS),
    localparam int IW   = idx_width(NREQ)
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    ram_port_arbiter_if.slave  bus,
    output logic     [AW-1:0]  ram_addr,
    output logic               ram_wr,
    output logic     [DW-1:0]  ram_din,
    input  wire logic [DW-1:0] ram_qout
);

    logic [NREQ-1:0] w_req;
    logic [NREQ-1:0] w_gnt;
    logic [IW-1:0]   w_idx;
    logic            w_any;
    logic [NREQ-1:0] r_rsp_sel;

    // Reset masks the requests so no grant (and no write) can leak out.
    assign w_req = bus.req_valid & {NREQ{rst_n}};
    assign w_any = |w_gnt;

    rr_arbiter #(
        .NREQ (NREQ)
    ) u_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_req     (w_req),
        .i_advance (w_any),
        .o_gnt     (w_gnt),
        .o_gnt_idx (w_idx)
    );

    assign bus.req_ready = w_gnt;

    // Route the granted requester's command to the RAM, idle command otherwise.
    always_comb begin
        ram_addr = AW'(IDLE_ADDR);
        ram_wr   = IDLE_WR;
        ram_din  = DW'(IDLE_DIN);
        if (w_any) begin
            ram_addr = bus.req_addr[w_idx];
            ram_wr   = bus.req_wr[w_idx];
            ram_din  = bus.req_din[w_idx];
        end
    end

    // Remember who was accepted so the RAM word is steered back next cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rsp_sel <= '0;
        end else begin
            r_rsp_sel <= w_gnt;
        end
    end

    // A response due in a reset cycle is dropped.
    assign bus.rsp_valid = r_rsp_sel & {NREQ{rst_n}};
    assign bus.rsp_data  = ram_qout;

endmodule
`default_nettype wire

// File: tb/tb_ram_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ram_port_arbiter
//  Purpose  : Directed self-checking bench for ram_port_arbiter with a
//             read-first, 1-cycle-latency RAM model on the arbiter port.
//  Revision : 1.0  initial release
// ============================================================================
module tb_ram_port_arbiter;

    localparam int NREQ  = 4;
    localparam int DW    = 8;
    localparam int WORDS = 256;
    localparam int AW    = 8;

    logic          clk;
    logic          rst_n;
    logic [AW-1:0] ram_addr;
    logic          ram_wr;
    logic [DW-1:0] ram_din;
    logic [DW-1:0] ram_qout;
    logic [DW-1:0] mem [WORDS];

    int checks = 0;
    int errors = 0;

    ram_port_arbiter_if #(.NREQ(NREQ), .DW(DW), .AW(AW)) bus ();

    ram_port_arbiter #(
        .NREQ  (NREQ),
        .DW    (DW),
        .WORDS (WORDS)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .ram_addr (ram_addr),
        .ram_wr   (ram_wr),
        .ram_din  (ram_din),
        .ram_qout (ram_qout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single-port view of the RAM: registered read, read-first on write.
    always @(posedge clk) begin
        ram_qout <= mem[ram_addr];
        if (ram_wr) mem[ram_addr] <= ram_din;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n         = 1'b0;
        bus.req_valid = 4'b1111;
        bus.req_wr    = 4'b1111;
        for (int i = 0; i < NREQ; i++) begin
            bus.req_addr[i] = AW'(8'h40 + i);
            bus.req_din[i]  = '0;
        end

        // Reset held with everyone requesting writes.
        repeat (3) begin
            @(negedge clk);
            check("rst_ready",     32'(bus.req_ready), 32'h0);
            check("rst_ram_wr",    32'(ram_wr),        32'h0);
            check("rst_rsp_valid", 32'(bus.rsp_valid), 32'h0);
        end
        next_cycle();
        rst_n      = 1'b1;
        bus.req_wr = 4'b0000;

        // Full contention: 0,1,2,3,0,1,2,3 with responses one cycle behind.
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check("cont_ready", 32'(bus.req_ready), 32'(1 << (k % 4)));
            check("cont_addr",  32'(ram_addr),      32'(8'h40 + (k % 4)));
            if (k > 0) check("cont_rsp", 32'(bus.rsp_valid), 32'(1 << ((k - 1) % 4)));
            else       check("cont_rsp_first", 32'(bus.rsp_valid), 32'h0);
            next_cycle();
        end
        bus.req_valid = 4'b0000;
        @(negedge clk);
        check("cont_rsp_last", 32'(bus.rsp_valid), 32'h8);
        check("idle_ready",    32'(bus.req_ready), 32'h0);
        check("idle_addr",     32'(ram_addr),      32'h0);
        check("idle_wr",       32'(ram_wr),        32'h0);
        next_cycle();

        // Requester 2: write 0x10=0x33, write 0x10=0xA5, read 0x10.
        bus.req_valid   = 4'b0100;
        bus.req_wr      = 4'b0100;
        bus.req_addr[2] = 8'h10;
        bus.req_din[2]  = 8'h33;
        @(negedge clk);
        check("r2_pre_ready", 32'(bus.req_ready), 32'h4);
        check("r2_pre_wr",    32'(ram_wr),        32'h1);
        check("r2_pre_addr",  32'(ram_addr),      32'h10);
        check("r2_pre_din",   32'(ram_din),       32'h33);
        next_cycle();
        bus.req_din[2] = 8'hA5;
        @(negedge clk);
        check("r2_wr_ready",  32'(bus.req_ready), 32'h4);
        check("r2_wr_din",    32'(ram_din),       32'hA5);
        check("r2_pre_rsp",   32'(bus.rsp_valid), 32'h4);
        next_cycle();
        bus.req_wr = 4'b0000;
        @(negedge clk);
        check("r2_rd_ready",  32'(bus.req_ready), 32'h4);
        check("r2_rd_ramwr",  32'(ram_wr),        32'h0);
        check("r2_wr_rsp",    32'(bus.rsp_valid), 32'h4);
        check("r2_wr_old",    32'(bus.rsp_data),  32'h33);
        next_cycle();
        bus.req_valid = 4'b0000;
        @(negedge clk);
        check("r2_rd_rsp",    32'(bus.rsp_valid), 32'h4);
        check("r2_rd_data",   32'(bus.rsp_data),  32'hA5);
        next_cycle();

        // Skip and wrap: ptr = 3, requesters 1 and 3 valid -> 3, 1, 3.
        bus.req_valid = 4'b1010;
        @(negedge clk);
        check("wrap_g0", 32'(bus.req_ready), 32'h8);
        next_cycle();
        @(negedge clk);
        check("wrap_g1",  32'(bus.req_ready), 32'h2);
        check("wrap_r0",  32'(bus.rsp_valid), 32'h8);
        next_cycle();
        @(negedge clk);
        check("wrap_g2",  32'(bus.req_ready), 32'h8);
        check("wrap_r1",  32'(bus.rsp_valid), 32'h2);
        next_cycle();
        bus.req_valid = 4'b0000;
        @(negedge clk);
        check("wrap_r2",  32'(bus.rsp_valid), 32'h8);
        next_cycle();

        // Read-during-write: 0x20 preloaded with 0x7E, then overwritten with 0x11.
        bus.req_valid   = 4'b0001;
        bus.req_wr      = 4'b0001;
        bus.req_addr[0] = 8'h20;
        bus.req_din[0]  = 8'h7E;
        @(negedge clk);
        check("rdw_pre_ready", 32'(bus.req_ready), 32'h1);
        next_cycle();
        bus.req_din[0] = 8'h11;
        @(negedge clk);
        check("rdw_wr_ready",  32'(bus.req_ready), 32'h1);
        check("rdw_wr_din",    32'(ram_din),       32'h11);
        next_cycle();
        bus.req_valid   = 4'b0010;
        bus.req_wr      = 4'b0000;
        bus.req_addr[1] = 8'h20;
        @(negedge clk);
        check("rdw_rd_ready",  32'(bus.req_ready), 32'h2);
        check("rdw_wr_rsp",    32'(bus.rsp_valid), 32'h1);
        check("rdw_wr_old",    32'(bus.rsp_data),  32'h7E);
        next_cycle();
        bus.req_valid = 4'b0000;
        @(negedge clk);
        check("rdw_rd_rsp",    32'(bus.rsp_valid), 32'h2);
        check("rdw_rd_data",   32'(bus.rsp_data),  32'h11);
        next_cycle();

        // Reset right after requester 1 is accepted (ptr = 2 here).
        bus.req_valid = 4'b0010;
        @(negedge clk);
        check("mid_ready",     32'(bus.req_ready), 32'h2);
        next_cycle();
        rst_n         = 1'b0;
        bus.req_valid = 4'b1111;
        @(negedge clk);
        check("mid_rsp_drop",  32'(bus.rsp_valid), 32'h0);
        check("mid_rst_ready", 32'(bus.req_ready), 32'h0);
        next_cycle();
        rst_n = 1'b1;
        @(negedge clk);
        check("mid_ptr0",      32'(bus.req_ready), 32'h1);
        check("mid_rsp_none",  32'(bus.rsp_valid), 32'h0);
        next_cycle();
        bus.req_valid = 4'b0000;
        @(negedge clk);
        check("mid_rsp_after", 32'(bus.rsp_valid), 32'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
